ifu_fetch: RTL
==============

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch unit; the consumer side of the writeback PC-update handshake.
//  - Takes the architectural PC (pc_in) and the writeback-done strobe (pc_update_en).
//  - Fetches one instruction per PC over a valid/ready request + valid response memory port.
//  - Presents inst/inst_valid, held until writeback commits it; one instruction in flight.
// PARAMETERS
//  ERR_INST        32'h0000_0000  instruction word presented when fetch_err=1
//  TIMEOUT_CYCLES  255            S_WAIT cycles before forced error (IFU_TIMEOUT_EN only)
//  TIMEOUT_W       8              timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst             in   1   synchronous, active-high reset
//  pc_in           in   32  current PC from writeback (resets to 32'h8000_0000 there)
//  pc_update_en    in   1   writeback committed current inst; PC changes on this edge
//  imem_req_valid  out  1   fetch request valid
//  imem_req_addr   out  32  fetch address (= pc_in while requesting)
//  imem_req_ready  in   1   memory accepts request when valid&&ready
//  imem_resp_valid in   1   response data valid (1-cycle strobe)
//  imem_resp_data  in   32  fetched instruction word
//  imem_resp_err   in   1   bus error with response
//  inst            out  32  registered instruction word
//  inst_pc         out  32  PC the instruction was fetched from
//  inst_valid      out  1   inst/inst_pc/fetch_err valid, held until pc_update_en
//  fetch_err       out  1   misaligned, bus-error or timeout fetch; inst=ERR_INST
// BEHAVIOUR
//  Reset (sync): state=S_REQ; inst_valid=0, fetch_err=0, inst=0, inst_pc=0, req_valid=0 in the reset cycle.
//  FSM S_REQ -> S_WAIT -> S_HOLD -> S_REQ:
//   S_REQ:  pc_in[1:0]!=0 -> no request; latch inst=ERR_INST, inst_pc=pc_in, fetch_err=1, inst_valid=1 -> S_HOLD.
//           else req_valid=1, req_addr=pc_in; valid&&ready -> latch inst_pc=pc_in -> S_WAIT.
//           Once asserted, req_valid/addr hold stable until ready.
//   S_WAIT: req_valid=0; resp_valid -> inst=resp_err?ERR_INST:resp_data, fetch_err=resp_err, inst_valid=1 -> S_HOLD.
//   S_HOLD: outputs stable; pc_update_en -> inst_valid=0, fetch_err=0 next cycle -> S_REQ.
//           pc_in is already the new PC in that next cycle.
//  Latency: request accepted cycle N, resp cycle N+k (k>=1) -> inst_valid=1 from cycle N+k+1.
//  Minimum issue rate: one instruction per 3 cycles (REQ, WAIT, HOLD).
//  resp_valid in S_REQ/S_HOLD: ignored (no state change). Same-cycle response with acceptance not allowed.
//  pc_update_en outside S_HOLD: ignored; flagged by a bench assertion.
//  Reset mid-fetch: immediate return to S_REQ; the memory side is reset on the same rst,
//   so stale responses are not expected and are ignored if seen in S_REQ.
//  inst_valid=1 implies state==S_HOLD; imem_req_valid=1 implies state==S_REQ.
// CONFIGURATION
//  IFU_TIMEOUT_EN defined:
//   TIMEOUT_W counter clears on S_WAIT entry and increments each S_WAIT cycle without resp_valid.
//   At TIMEOUT_CYCLES: inst=ERR_INST, fetch_err=1, inst_valid=1 -> S_HOLD; later resp_valid ignored.
//  IFU_TIMEOUT_EN undefined: no counter; S_WAIT waits indefinitely.
// STRUCTURE
//  Package ifu_pkg: state enum {S_REQ,S_WAIT,S_HOLD} (2-bit), RESET_PC=32'h8000_0000 (bench use), ERR_INST default.
//  One sub-module ifu_timeout_ctr (clear/enable/expired), instantiated only under IFU_TIMEOUT_EN.
//  Otherwise a single always block for state and registered outputs; req_valid/addr combinational from state.
// TESTING
//  1 Reset, pc_in=0x8000_0000, ready=1, resp 1 cyc later data=0x0000_0093 -> req_addr=0x8000_0000; inst_valid at cycle 3 with inst=0x93.
//  2 Hold: keep pc_update_en=0 for 10 cycles -> inst_valid stays 1, no new request.
//    Then pulse with pc_in->0x8000_0004 -> next req_addr=0x8000_0004.
//  3 Backpressure: ready=0 for 5 cycles -> req_valid held and req_addr stable; accepted on 6th.
//  4 pc_in=0x8000_0002 -> no req_valid; inst_valid=1, fetch_err=1, inst=ERR_INST, inst_pc=0x8000_0002.
//  5 resp_err=1 with data=0xDEAD_BEEF -> inst=ERR_INST, fetch_err=1; next pc_update_en clears fetch_err.
//  6 rst pulsed in S_WAIT, then resp_valid next cycle -> ignored; new request issued.
//    With IFU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no resp -> fetch_err after 4 WAIT cycles.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The optional fetch timeout is enabled with the IFU_TIMEOUT_EN macro.
package ifu_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_t;

  localparam logic [31:0] RESET_PC         = 32'h8000_0000;
  localparam logic [31:0] ERR_INST_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifu_timeout_ctr.sv
// Wait-state watchdog for the fetch unit; built only when IFU_TIMEOUT_EN is defined.
// expired pulses combinationally in the enabled cycle that reaches LIMIT waited cycles.
module ifu_timeout_ctr #(
  parameter int LIMIT = 255,
  parameter int W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one fetch in flight, instruction held until writeback commits it.
// Define IFU_TIMEOUT_EN to force an error fetch after TIMEOUT_CYCLES waiting for a response.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] ERR_INST       = ERR_INST_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_update_en,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        fetch_err,
  output logic [1:0]  state_dbg
);

  // Handshake: a request transfers on a cycle where imem_req_valid && imem_req_ready;
  // once raised, valid and addr stay stable until that cycle. The response is a
  // single-cycle imem_resp_valid strobe with no back-pressure from this side.

  ifu_state_t  state_q, state_d;
  logic [31:0] inst_d, inst_pc_d;
  logic        inst_valid_d, fetch_err_d;
  logic        aligned, req_fire, tmo_expired;

  assign aligned        = (pc_in[1:0] == 2'b00);
  assign imem_req_valid = !rst && (state_q == S_REQ) && aligned;
  assign imem_req_addr  = pc_in;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign state_dbg      = state_q;

`ifdef IFU_TIMEOUT_EN
  ifu_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TIMEOUT_W)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear   (req_fire),
    .enable  ((state_q == S_WAIT) && !imem_resp_valid),
    .expired (tmo_expired)
  );
`else
  // No watchdog: S_WAIT waits indefinitely; parameters stay for a uniform interface.
  assign tmo_expired = 1'b0 & (TIMEOUT_W > 0) & (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d      = state_q;
    inst_d       = inst;
    inst_pc_d    = inst_pc;
    inst_valid_d = inst_valid;
    fetch_err_d  = fetch_err;
    unique case (state_q)
      S_REQ: begin
        if (!aligned) begin
          inst_d       = ERR_INST;
          inst_pc_d    = pc_in;
          fetch_err_d  = 1'b1;
          inst_valid_d = 1'b1;
          state_d      = S_HOLD;
        end else if (req_fire) begin
          inst_pc_d = pc_in;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          inst_d       = imem_resp_err ? ERR_INST : imem_resp_data;
          fetch_err_d  = imem_resp_err;
          inst_valid_d = 1'b1;
          state_d      = S_HOLD;
        end else if (tmo_expired) begin
          inst_d       = ERR_INST;
          fetch_err_d  = 1'b1;
          inst_valid_d = 1'b1;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (pc_update_en) begin
          inst_valid_d = 1'b0;
          fetch_err_d  = 1'b0;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inst       <= inst_d;
      inst_pc    <= inst_pc_d;
      inst_valid <= inst_valid_d;
      fetch_err  <= fetch_err_d;
    end
  end

endmodule
